// File: rtl/cmd_auth_pkg.sv
// Shared types and default command bytes for the BLE power-authorization block.
package cmd_auth_pkg;

  typedef enum logic [1:0] {
    AUTH_OFF  = 2'd0,
    AUTH_PWR1 = 2'd1,
    AUTH_PWR2 = 2'd2
  } auth_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] GO_CMD_DEF   = 8'h47;
  localparam logic [7:0] STOP_CMD_DEF = 8'h53;

endpackage

// File: rtl/cmd_auth_uart_rx.sv
// 8N1 UART receiver: synchronizes RX, times each bit from the start edge and
// publishes a byte with a one-cycle rx_rdy pulse only when the stop bit is high.
module uart_rx
  import cmd_auth_pkg::*;
#(
  parameter int BAUD_CYC = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);

  localparam int CW = $clog2(BAUD_CYC + 1);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_CYC);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_CYC / 2);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          rdy_q, rdy_d;
  logic          fall_edge, expire;

  // Synchronizer flops idle high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall_edge = rx_prev_q & ~rx_sync_q;
  assign expire    = (baud_q == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (fall_edge) begin
          state_d = RX_START;
          baud_d  = BAUD_HALF;
          bit_d   = '0;
        end
      end
      RX_START: begin
        if (!expire) begin
          baud_d = baud_q - CW'(1);
        end else if (!rx_sync_q) begin
          state_d = RX_DATA;
          baud_d  = BAUD_FULL;
        end else begin
          state_d = RX_IDLE;
          baud_d  = '0;
        end
      end
      RX_DATA: begin
        if (!expire) begin
          baud_d = baud_q - CW'(1);
        end else begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          baud_d  = BAUD_FULL;
          if (bit_q == 4'd7) begin
            state_d = RX_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (!expire) begin
          baud_d = baud_q - CW'(1);
        end else begin
          state_d = RX_IDLE;
          baud_d  = '0;
          if (rx_sync_q) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_data = data_q;
  assign rx_rdy  = rdy_q;

endmodule

// File: rtl/cmd_auth.sv
// Segway power authorization: a received GO byte enables the motors, STOP
// disables them once the rider has stepped off.
module cmd_auth
  import cmd_auth_pkg::*;
#(
  parameter int         BAUD_CYC = 2604,
  parameter logic [7:0] GO_CMD   = GO_CMD_DEF,
  parameter logic [7:0] STOP_CMD = STOP_CMD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);

  auth_state_e state_q, state_d;
  logic        go_seen, stop_seen;

  uart_rx #(
    .BAUD_CYC(BAUD_CYC)
  ) u_rx (
    .clk    (clk),
    .rst    (rst),
    .RX     (RX),
    .rx_data(rx_data),
    .rx_rdy (rx_rdy)
  );

  assign go_seen   = rx_rdy && (rx_data == GO_CMD);
  assign stop_seen = rx_rdy && (rx_data == STOP_CMD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= AUTH_OFF;
    else     state_q <= state_d;
  end

  // A STOP with the rider still aboard parks in PWR2 until they step off.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AUTH_OFF:  if (go_seen) state_d = AUTH_PWR1;
      AUTH_PWR1: if (stop_seen) state_d = rider_off ? AUTH_OFF : AUTH_PWR2;
      AUTH_PWR2: begin
        if (rider_off)    state_d = AUTH_OFF;
        else if (go_seen) state_d = AUTH_PWR1;
      end
      default: state_d = AUTH_OFF;
    endcase
  end

  assign pwr_up = (state_q != AUTH_OFF);

endmodule

// File: tb/tb_cmd_auth.sv
// Scoreboard bench for cmd_auth: frames are queued as they are driven and
// checked (data, latency, auth state) when rx_rdy appears.
module tb_cmd_auth;

  localparam int B = 16;
  localparam int L = B / 2 + 9 * B + 2;

  typedef struct {
    logic [7:0] data;
    int         startCyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       rider_off = 1'b0;
  logic       pwr_up;
  logic [7:0] rx_data;
  logic       rx_rdy;

  exp_t       sbQ[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         modelState = 0;
  logic       prevRdy = 1'b0;
  logic [7:0] prevData = 8'h00;
  int         lastRdyCyc = 0;
  int         lastGap = 0;

  cmd_auth #(
    .BAUD_CYC(B),
    .GO_CMD  (8'h47),
    .STOP_CMD(8'h53)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .rider_off(rider_off),
    .pwr_up   (pwr_up),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: advance the auth model on the inputs the DUT saw at this edge,
  // then consume any rx_rdy pulse from the scoreboard.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      modelState = 0;
      prevRdy    = 1'b0;
      checkOutput("rx_rdy in reset", {31'd0, rx_rdy}, 32'd0);
    end else begin
      case (modelState)
        0: if (prevRdy && prevData == 8'h47) modelState = 1;
        1: if (prevRdy && prevData == 8'h53) modelState = rider_off ? 0 : 2;
        2: begin
          if (rider_off) modelState = 0;
          else if (prevRdy && prevData == 8'h47) modelState = 1;
        end
        default: modelState = 0;
      endcase
    end
    checkOutput("pwr_up model", {31'd0, pwr_up}, {31'd0, modelState != 0});
    prevRdy = 1'b0;
    if (rx_rdy && !rst) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected rx_rdy", 32'd1, 32'd0);
      end else begin
        exp_t e;
        int   d;
        e = sbQ.pop_front();
        d = cyc - e.startCyc;
        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        checkOutput("rdy latency", d, (d >= L - 1 && d <= L + 1) ? d : L);
        prevRdy    = 1'b1;
        prevData   = e.data;
        lastGap    = cyc - lastRdyCyc;
        lastRdyCyc = cyc;
      end
    end
  end

  // Caller must be sitting on a negedge; the frame starts immediately.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int gap);
    RX = 1'b0;
    if (stopBit) sbQ.push_back('{data: b, startCyc: cyc + 1});
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = stopBit;
    repeat (B) @(negedge clk);
    RX = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] partial;
    partial = 8'h47;
    repeat (3) @(negedge clk);
    checkOutput("reset rx_data", {24'd0, rx_data}, 32'h0);
    checkOutput("reset rx_rdy", {31'd0, rx_rdy}, 32'd0);
    checkOutput("reset pwr_up", {31'd0, pwr_up}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] GO from OFF");
    applyStimulus(8'h47, 1'b1, 8);
    checkOutput("go pwr_up", {31'd0, pwr_up}, 32'd1);
    checkOutput("go rx_data", {24'd0, rx_data}, 32'h47);

    $display("[TB] STOP with rider aboard, then rider steps off");
    applyStimulus(8'h53, 1'b1, 8);
    checkOutput("stop rider on pwr_up", {31'd0, pwr_up}, 32'd1);
    rider_off = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rider off pwr_up", {31'd0, pwr_up}, 32'd0);

    $display("[TB] GO then STOP with rider off");
    applyStimulus(8'h47, 1'b1, 8);
    checkOutput("go rider off pwr_up", {31'd0, pwr_up}, 32'd1);
    applyStimulus(8'h53, 1'b1, 8);
    checkOutput("stop rider off pwr_up", {31'd0, pwr_up}, 32'd0);
    rider_off = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] framing error and glitch");
    applyStimulus(8'h47, 1'b0, 2 * B);
    checkOutput("framing rx_data", {24'd0, rx_data}, 32'h53);
    checkOutput("framing pwr_up", {31'd0, pwr_up}, 32'd0);
    RX = 1'b0;
    @(negedge clk);
    RX = 1'b1;
    repeat (12 * B) @(negedge clk);
    checkOutput("glitch rx_data", {24'd0, rx_data}, 32'h53);
    checkOutput("glitch pwr_up", {31'd0, pwr_up}, 32'd0);

    $display("[TB] back-to-back frames");
    applyStimulus(8'h41, 1'b1, 0);
    checkOutput("after 0x41 pwr_up", {31'd0, pwr_up}, 32'd0);
    applyStimulus(8'h47, 1'b1, 8);
    checkOutput("b2b gap", lastGap, 10 * B);
    checkOutput("b2b pwr_up", {31'd0, pwr_up}, 32'd1);

    $display("[TB] reset mid-frame");
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = partial[i];
      repeat (B) @(negedge clk);
    end
    RX = partial[4];
    repeat (B / 2) @(negedge clk);
    rst = 1'b1;
    RX  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("mid reset pwr_up", {31'd0, pwr_up}, 32'd0);
    rst = 1'b0;
    repeat (12 * B) @(negedge clk);
    checkOutput("post reset pwr_up", {31'd0, pwr_up}, 32'd0);
    checkOutput("post reset rx_data", {24'd0, rx_data}, 32'h0);
    applyStimulus(8'h47, 1'b1, 8);
    checkOutput("recover rx_data", {24'd0, rx_data}, 32'h47);
    checkOutput("recover pwr_up", {31'd0, pwr_up}, 32'd1);

    for (int i = 0; i < 20 * B && sbQ.size() != 0; i++) @(negedge clk);
    checkOutput("pending frames", sbQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
